rr_decode_arbiter: RTL and testbench



---
 rtl/rr_decode_arbiter.sv | 120 ++++++++++++
 tb/tb_rr_decode_arbiter.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/rr_decode_arbiter.sv
// Round-robin arbiter: 8 requesters share one 3-to-8 decoded resource; grant held until release.
// Optional TIMEOUT_EN adds a HOLD_MAX-cycle forced revoke with a timeout_err pulse.
module rr_decode_arbiter #(
    parameter int HOLD_MAX = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] req,
    input  logic       done,
    output logic       grant_valid,
    output logic [2:0] grant_idx,
    output logic [7:0] grant_oh,
    output logic       busy,
    output logic       timeout_err
);
    typedef enum logic {IDLE, GRANT} state_e;

    if (HOLD_MAX < 2 || HOLD_MAX > 255) begin : g_hold_max_range
        $error("rr_decode_arbiter: HOLD_MAX must be in 2..255");
    end

    state_e     state_q, state_d;
    logic [2:0] ptr_q, ptr_d;
    logic [2:0] idx_q, idx_d;
    logic [7:0] oh_q, oh_d;
    logic       tout_q, tout_d;
    logic [2:0] pick;
    logic       pick_vld;
    logic       release_w;
    logic       expire;

    // First set request scanning from ptr upward, wrapping mod 8.
    always_comb begin
        logic [2:0] k;
        pick     = '0;
        pick_vld = 1'b0;
        k        = '0;
        for (int i = 0; i < 8; i++) begin
            k = ptr_q + 3'(i);
            if (!pick_vld && req[k]) begin
                pick     = k;
                pick_vld = 1'b1;
            end
        end
    end

    assign release_w = done | ~req[idx_q];

`ifdef TIMEOUT_EN
    logic [7:0] hold_q;

    // Counts GRANT cycles; sits at zero while idle so each grant starts fresh.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                 hold_q <= '0;
        else if (state_q == IDLE) hold_q <= '0;
        else                      hold_q <= hold_q + 8'd1;
    end

    assign expire = (state_q == GRANT) && (hold_q == 8'(HOLD_MAX - 1));
`else
    assign expire = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            idx_q   <= '0;
            oh_q    <= '0;
            tout_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            idx_q   <= idx_d;
            oh_q    <= oh_d;
            tout_q  <= tout_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (pick_vld) state_d = GRANT;
            GRANT:   if (release_w || expire) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Release beats timeout: only a revoke with no concurrent release flags an error.
    always_comb begin
        ptr_d  = ptr_q;
        idx_d  = '0;
        oh_d   = '0;
        tout_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (pick_vld) begin
                    idx_d = pick;
                    oh_d  = 8'd1 << pick;
                end
            end
            GRANT: begin
                if (release_w || expire) begin
                    ptr_d  = idx_q + 3'd1;
                    tout_d = expire & ~release_w;
                end else begin
                    idx_d = idx_q;
                    oh_d  = oh_q;
                end
            end
            default: ;
        endcase
    end

    assign grant_valid = (state_q == GRANT);
    assign busy        = (state_q == GRANT);
    assign grant_idx   = idx_q;
    assign grant_oh    = oh_q;
    assign timeout_err = tout_q;
endmodule

// File: tb/tb_rr_decode_arbiter.sv
// Bench for rr_decode_arbiter: vector table, directed corner sequences, random vs. reference model.
module tb_rr_decode_arbiter;
`ifdef TIMEOUT_EN
    localparam int HM = 4;
`else
    localparam int HM = 16;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] req = '0;
    logic       done = 1'b0;
    logic       grant_valid, busy, timeout_err;
    logic [2:0] grant_idx;
    logic [7:0] grant_oh;

    int total = 0;
    int bad   = 0;

    rr_decode_arbiter #(.HOLD_MAX(HM)) dut (
        .clk(clk), .rst(rst), .req(req), .done(done),
        .grant_valid(grant_valid), .grant_idx(grant_idx), .grant_oh(grant_oh),
        .busy(busy), .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] req;
        logic       done;
        logic       v;
        logic [2:0] idx;
    } vec_t;

    vec_t tbl[15];

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_out(input string name, input logic v, input int idx, input logic to);
        int oh;
        oh = v ? (1 << idx) : 0;
        chk({name, ".valid"}, int'(grant_valid), int'(v));
        chk({name, ".busy"},  int'(busy),        int'(v));
        chk({name, ".idx"},   int'(grant_idx),   v ? idx : 0);
        chk({name, ".oh"},    int'(grant_oh),    oh);
        chk({name, ".tout"},  int'(timeout_err), int'(to));
    endtask

    task automatic do_reset();
        rst  = 1'b1;
        req  = '0;
        done = 1'b0;
        repeat (2) step();
        chk_out("reset", 1'b0, 0, 1'b0);
        rst = 1'b0;
    endtask

    // Reference model: grant state as plain integers
    bit m_g, m_to;
    int m_owner, m_ptr, m_held;

    task automatic model_step(input logic [7:0] r, input logic d);
        bit rel, tmo;
        m_to = 1'b0;
        if (!m_g) begin
            for (int i = 0; i < 8; i++) begin
                int k;
                k = (m_ptr + i) % 8;
                if (!m_g && r[k]) begin
                    m_g = 1'b1; m_owner = k; m_held = 1;
                end
            end
        end else begin
            rel = d || !r[m_owner];
`ifdef TIMEOUT_EN
            tmo = (m_held == HM);
`else
            tmo = 1'b0;
`endif
            if (rel || tmo) begin
                m_g = 1'b0; m_ptr = (m_owner + 1) % 8; m_to = tmo && !rel;
            end else begin
                m_held++;
            end
        end
    endtask

    initial begin
        int errs;

        // vector table from reset: ptr walks 0 -> 3 -> 6 -> 3 -> 4 -> 1 -> 4
        tbl[0]  = '{8'h24, 1'b0, 1'b1, 3'd2};
        tbl[1]  = '{8'h24, 1'b1, 1'b0, 3'd0};
        tbl[2]  = '{8'h24, 1'b0, 1'b1, 3'd5};
        tbl[3]  = '{8'h24, 1'b1, 1'b0, 3'd0};
        tbl[4]  = '{8'h24, 1'b0, 1'b1, 3'd2};
        tbl[5]  = '{8'h24, 1'b0, 1'b1, 3'd2};
        tbl[6]  = '{8'h00, 1'b0, 1'b0, 3'd0};
        tbl[7]  = '{8'h08, 1'b0, 1'b1, 3'd3};
        tbl[8]  = '{8'h08, 1'b0, 1'b1, 3'd3};
        tbl[9]  = '{8'h00, 1'b0, 1'b0, 3'd0};
        tbl[10] = '{8'h09, 1'b0, 1'b1, 3'd0};
        tbl[11] = '{8'h09, 1'b1, 1'b0, 3'd0};
        tbl[12] = '{8'h09, 1'b0, 1'b1, 3'd3};
        tbl[13] = '{8'h00, 1'b1, 1'b0, 3'd0};
        tbl[14] = '{8'h00, 1'b1, 1'b0, 3'd0};

        do_reset();

        // idle with no requests
        errs = 0;
        for (int i = 0; i < 10; i++) begin
            step();
            if (grant_valid !== 1'b0 || grant_oh !== 8'h00) errs++;
        end
        chk("idle_no_req", errs, 0);

        for (int i = 0; i < 15; i++) begin
            req  = tbl[i].req;
            done = tbl[i].done;
            step();
            chk_out($sformatf("vec%0d", i), tbl[i].v, int'(tbl[i].idx), 1'b0);
        end

        // full request vector, release every grant: 0..7,0 with a gap each time
        do_reset();
        req = 8'hFF;
        for (int g = 0; g < 9; g++) begin
            done = 1'b0;
            step();
            chk_out($sformatf("ff_grant%0d", g), 1'b1, g % 8, 1'b0);
            done = 1'b1;
            step();
            chk_out($sformatf("ff_gap%0d", g), 1'b0, 0, 1'b0);
        end
        done = 1'b0;

        // asynchronous reset between edges drops the grant at once
        req = 8'h10;
        step();
        chk_out("pre_async", 1'b1, 4, 1'b0);
        #3 rst = 1'b1;
        #1;
        chk("async.valid", int'(grant_valid), 0);
        chk("async.oh", int'(grant_oh), 0);
        step();
        rst = 1'b0;
        req = 8'h80;
        step();
        chk_out("post_async", 1'b1, 7, 1'b0);

        // single requester, done never asserted
        do_reset();
        req = 8'h01;
`ifdef TIMEOUT_EN
        for (int c = 0; c < 4; c++) begin
            step();
            chk_out($sformatf("tmo_hold%0d", c), 1'b1, 0, 1'b0);
        end
        step();
        chk_out("tmo_pulse", 1'b0, 0, 1'b1);
        step();
        chk_out("tmo_regrant", 1'b1, 0, 1'b0);
        // release on the timeout cycle is a normal release
        step(); step(); step();
        done = 1'b1;
        step();
        chk_out("tmo_rel_same", 1'b0, 0, 1'b0);
        done = 1'b0;
`else
        errs = 0;
        for (int c = 0; c < 120; c++) begin
            step();
            if (grant_valid !== 1'b1 || grant_idx !== 3'd0 || timeout_err !== 1'b0) errs++;
        end
        chk("hold_forever", errs, 0);
`endif

        // randomized run against the reference model
        do_reset();
        m_g = 1'b0; m_to = 1'b0; m_owner = 0; m_ptr = 0; m_held = 0;
        for (int c = 0; c < 600; c++) begin
            req  = 8'($urandom) & 8'($urandom) & 8'($urandom);
            if ($urandom_range(0, 3) == 0) req = 8'($urandom);
            done = ($urandom_range(0, 3) == 0);
            model_step(req, done);
            step();
            chk_out($sformatf("rnd%0d", c), m_g, m_owner, m_to);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
